// File: rtl/mem_arbiter_2port.sv
// Two-master arbiter and sequencer for the single-port word memory (IDLE -> ISSUE -> COMPLETE).
// Optional feature macro MEM_ARB_RR_EN: round-robin tie-breaking; undefined gives fixed port-0 priority.
module mem_arbiter_2port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rE,
  output logic              mem_wE,
  input  logic [DATA_W-1:0] mem_dataOut
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [1:0]        gnt_next;
  logic              done0_next, done1_next;
  logic [DATA_W-1:0] rdata_next;
  logic [DATA_W-1:0] mem_data_next;
  logic [ADDR_W-1:0] mem_address_next;
  logic              mem_rE_next, mem_wE_next;
  logic              lat_we, lat_we_next;

  logic              elig0, elig1, pick1;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // A port seeing its done pulse is not eligible, so it cannot be re-granted in that cycle
  assign elig0 = req0 & ~done0;
  assign elig1 = req1 & ~done1;

`ifdef MEM_ARB_RR_EN
  logic last1, last1_next;

  assign pick1 = elig1 & (~elig0 | ~last1);
`else
  assign pick1 = elig1 & ~elig0;
`endif

  assign win_we    = pick1 ? we1    : we0;
  assign win_addr  = pick1 ? addr1  : addr0;
  assign win_wdata = pick1 ? wdata1 : wdata0;

  always_comb begin
    state_next       = state;
    gnt_next         = gnt;
    done0_next       = 1'b0;
    done1_next       = 1'b0;
    rdata_next       = rdata;
    mem_data_next    = mem_data;
    mem_address_next = mem_address;
    mem_rE_next      = 1'b0;
    mem_wE_next      = 1'b0;
    lat_we_next      = lat_we;
`ifdef MEM_ARB_RR_EN
    last1_next       = last1;
`endif

    unique case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt_next         = pick1 ? 2'b10 : 2'b01;
          lat_we_next      = win_we;
          mem_address_next = win_addr;
          mem_data_next    = win_wdata;
          mem_wE_next      = win_we;
          mem_rE_next      = ~win_we;
          state_next       = ISSUE;
`ifdef MEM_ARB_RR_EN
          last1_next       = pick1;
`endif
        end
      end

      ISSUE: begin
        state_next = COMPLETE;
      end

      // Memory read data is valid during this cycle, one edge after the read strobe
      COMPLETE: begin
        if (!lat_we) begin
          rdata_next = mem_dataOut;
        end
        done0_next = gnt[0];
        done1_next = gnt[1];
        gnt_next   = 2'b00;
        state_next = IDLE;
      end

      default: begin
        gnt_next   = 2'b00;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata       <= '0;
      mem_data    <= '0;
      mem_address <= '0;
      mem_rE      <= 1'b0;
      mem_wE      <= 1'b0;
      lat_we      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last1       <= 1'b1;
`endif
    end else begin
      state       <= state_next;
      gnt         <= gnt_next;
      done0       <= done0_next;
      done1       <= done1_next;
      rdata       <= rdata_next;
      mem_data    <= mem_data_next;
      mem_address <= mem_address_next;
      mem_rE      <= mem_rE_next;
      mem_wE      <= mem_wE_next;
      lat_we      <= lat_we_next;
`ifdef MEM_ARB_RR_EN
      last1       <= last1_next;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Self-checking bench for mem_arbiter_2port: directed scenarios then random traffic,
// checked every cycle against a transaction-level model of the arbiter and a shadow memory.
module tb_mem_arbiter_2port;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt;
  logic        done0, done1;
  logic [31:0] rdata, mem_data, mem_dataOut;
  logic [5:0]  mem_address;
  logic        mem_rE, mem_wE;
  logic        memLoad;

  int checks = 0;
  int failures = 0;

  mem_arbiter_2port #(.DATA_W(32), .ADDR_W(6)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done0(done0), .done1(done1), .rdata(rdata),
    .mem_data(mem_data), .mem_address(mem_address),
    .mem_rE(mem_rE), .mem_wE(mem_wE), .mem_dataOut(mem_dataOut)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memInit(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Behavioural memory: synchronous write, registered read
  logic [31:0] memArr [64];
  always @(posedge clock) begin
    if (memLoad) begin
      for (int i = 0; i < 64; i++) memArr[i] <= memInit(i);
      mem_dataOut <= 32'h0;
    end else begin
      if (mem_wE) memArr[mem_address] <= mem_data;
      if (mem_rE) mem_dataOut <= memArr[mem_address];
    end
  end

  // Transaction-level reference: each grant at edge 'start' fixes what every output looks like
  // at offsets 0..2 after it, plus when the arbiter may decide again.
  logic [31:0] shadow [64];
  int          cyc = 0;
  int          start = 0;
  int          nextFree = 0;
  int          lastServed = 1;
  int          blockPort = -1;
  int          tPort = 0;
  bit          active = 0;
  logic        tWe = 1'b0;
  logic [5:0]  tAddr = '0;
  logic [31:0] tWdata = '0, tRdata = '0;
  logic [31:0] expRdata = '0, expData = '0;
  logic [5:0]  expAddr = '0;

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    bit e0, e1;
    int w;
    if (reset) begin
      active = 0; blockPort = -1; nextFree = cyc + 1; lastServed = 1;
      expRdata = '0; expAddr = '0; expData = '0;
      return;
    end
    if (active && cyc == start + 2 && !tWe) expRdata = tRdata;
    if (cyc >= nextFree) begin
      e0 = req0 && !(blockPort == 0 && cyc == nextFree);
      e1 = req1 && !(blockPort == 1 && cyc == nextFree);
      if (e0 || e1) begin
        if (e0 && e1) begin
`ifdef MEM_ARB_RR_EN
          w = (lastServed == 1) ? 0 : 1;
`else
          w = 0;
`endif
        end else begin
          w = e1 ? 1 : 0;
        end
        active = 1; start = cyc; tPort = w;
        tWe    = w ? we1 : we0;
        tAddr  = w ? addr1 : addr0;
        tWdata = w ? wdata1 : wdata0;
        if (tWe) shadow[tAddr] = tWdata;
        else     tRdata = shadow[tAddr];
        expAddr = tAddr; expData = tWdata;
        lastServed = w; blockPort = w; nextFree = cyc + 3;
      end
    end
  endtask

  task automatic checkOutput();
    int d;
    logic [1:0] eg;
    logic ew, er, ed0, ed1;
    d = cyc - start;
    eg = 2'b00; ew = 0; er = 0; ed0 = 0; ed1 = 0;
    if (active && d >= 0 && d <= 1) eg = (tPort == 1) ? 2'b10 : 2'b01;
    if (active && d == 0) begin ew = tWe; er = !tWe; end
    if (active && d == 2) begin ed0 = (tPort == 0); ed1 = (tPort == 1); end
    compare("gnt", gnt, eg);
    compare("done0", done0, ed0);
    compare("done1", done1, ed1);
    compare("mem_wE", mem_wE, ew);
    compare("mem_rE", mem_rE, er);
    compare("mem_address", mem_address, expAddr);
    compare("mem_data", mem_data, expData);
    compare("rdata", rdata, expRdata);
  endtask

  task automatic tick();
    cyc++;
    modelEdge();
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [5:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // Ticks until the port's done is seen; gives up after 10 cycles (latency then reads 10)
  task automatic waitDone(input int p, output int lat);
    lat = 0;
    while (lat < 10) begin
      tick();
      lat++;
      if ((p == 0) ? done0 : done1) break;
    end
  endtask

  initial begin
    int lat;
    int winners[$];
    logic prevBusy;
    bit rq[2];
    logic rw[2];
    logic [5:0] rad[2];
    logic [31:0] rwd[2];

    for (int i = 0; i < 64; i++) shadow[i] = memInit(i);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1; memLoad = 1;
    tick();
    memLoad = 0;
    tick();
    reset = 0;
    for (int i = 0; i < 5; i++) tick();

    $display("[TB] port 0 write then read");
    applyStimulus(1, 1, 6'd3, 32'h0000_00A5, 0, 0, 0, 0);
    tick();
    compare("wr_issue_wE", mem_wE, 1);
    compare("wr_issue_addr", mem_address, 3);
    compare("wr_issue_data", mem_data, 32'hA5);
    tick();
    compare("wr_wE_one_cycle", mem_wE, 0);
    tick();
    compare("wr_done0_lat3", done0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 6'd3, 0, 0, 0, 0, 0);
    waitDone(0, lat);
    compare("rd_latency", lat, 3);
    compare("rd_rdata", rdata, 32'h0000_00A5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] port 1 arrives during port 0 issue");
    applyStimulus(1, 0, 6'd5, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 6'd5, 0, 1, 1, 6'd6, 32'h1234_5678);
    tick();
    compare("ovl_gnt_owner0", gnt, 2'b01);
    tick();
    compare("ovl_done0_first", done0, 1);
    compare("ovl_gnt_idle", gnt, 2'b00);
    applyStimulus(0, 0, 0, 0, 1, 1, 6'd6, 32'h1234_5678);
    tick();
    compare("ovl_gnt_port1", gnt, 2'b10);
    waitDone(1, lat);
    compare("ovl_done1_lat", lat, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] simultaneous continuous requests");
    reset = 1;
    tick();
    reset = 0;
    applyStimulus(1, 0, 6'd1, 0, 1, 0, 6'd2, 0);
    prevBusy = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (gnt != 2'b00 && !prevBusy) winners.push_back(gnt == 2'b10 ? 1 : 0);
      prevBusy = (gnt != 2'b00);
    end
    compare("tie_count", winners.size(), 5);
    compare("tie_first_port0", winners[0], 0);
`ifdef MEM_ARB_RR_EN
    compare("rr_second", winners[1], 1);
    compare("rr_third", winners[2], 0);
    compare("rr_fourth", winners[3], 1);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] reset during complete");
    applyStimulus(1, 0, 6'd4, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1;
    tick();
    compare("rst_no_done0", done0, 0);
    compare("rst_gnt0", gnt, 2'b00);
    reset = 0;
    waitDone(0, lat);
    compare("rst_fresh_lat", lat, 3);
    compare("rst_fresh_rdata", rdata, memInit(4));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] random traffic");
    for (int p = 0; p < 2; p++) begin rq[p] = 0; rw[p] = 0; rad[p] = 0; rwd[p] = 0; end
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? done0 : done1) rq[p] = 0;
        if (!rq[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            rq[p] = 1; rw[p] = 1'($urandom_range(0, 1));
            rad[p] = 6'($urandom_range(0, 7)); rwd[p] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          rq[p] = 0;
        end else if ($urandom_range(0, 7) == 0) begin
          rad[p] = 6'($urandom_range(0, 7));
        end
      end
      applyStimulus(rq[0], rw[0], rad[0], rwd[0], rq[1], rw[1], rad[1], rwd[1]);
      reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
